// File: rtl/trex_collision_if.sv
// Registered-read port into the obstacle table: the collision block drives obs_idx
// and the obstacle manager returns that slot's contents one cycle later.
interface trex_collision_if #(
    parameter int unsigned IDX_W = 2
);
    logic [IDX_W-1:0] obs_idx;
    logic             obs_valid;
    logic [9:0]       obs_x;
    logic [9:0]       obs_y;
    logic [6:0]       obs_w;
    logic [6:0]       obs_h;

    modport master (
        output obs_idx,
        input  obs_valid,
        input  obs_x,
        input  obs_y,
        input  obs_w,
        input  obs_h
    );

    modport slave (
        input  obs_idx,
        output obs_valid,
        output obs_x,
        output obs_y,
        output obs_w,
        output obs_h
    );
endinterface

// File: rtl/trex_collision.sv
// Per-frame T-rex vs obstacle scan: walks the obstacle table, tests inset bounding-box
// overlap and raises a sticky crash flag with the lowest colliding slot index.
module trex_collision #(
    parameter int unsigned NUM_OBSTACLES = 3,
    parameter int unsigned INSET         = 2,
    parameter int unsigned IDX_W         = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_tick,
    input  logic [9:0]        trex_x,
    input  logic [9:0]        trex_y,
    input  logic [2:0]        trex_frame,
    trex_collision_if.master  obs,
    output logic              busy,
    output logic              done,
    output logic              crash,
    output logic [IDX_W-1:0]  hit_idx
);

    typedef enum logic [1:0] {StIdle, StReq, StCmp, StFin} state_e;

    localparam logic [10:0]      Ins     = 11'(INSET);
    localparam logic [10:0]      Ins2    = 11'(2 * INSET);
    localparam logic [10:0]      StandW  = 11'(44 - 2 * INSET);
    localparam logic [10:0]      StandH  = 11'(47 - 2 * INSET);
    localparam logic [10:0]      DuckW   = 11'(59 - 2 * INSET);
    localparam logic [10:0]      DuckH   = 11'(25 - 2 * INSET);
    localparam logic [10:0]      DuckDy  = 11'd22;
    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_OBSTACLES - 1);

    state_e           state_q, state_d;
    logic [9:0]       tx_q, tx_d;
    logic [9:0]       ty_q, ty_d;
    logic [2:0]       fr_q, fr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             found_q, found_d;
    logic [IDX_W-1:0] first_q, first_d;
    logic             crash_q, crash_d;
    logic [IDX_W-1:0] hit_q, hit_d;

    // Character box, derived from the frame captured at the tick.
    logic        duck;
    logic        armed;
    logic [10:0] a_x, a_y, a_w, a_h;

    always_comb begin
        duck  = (fr_q == 3'd5) || (fr_q == 3'd6);
        armed = (fr_q >= 3'd2) && (fr_q != 3'd7);
        a_x   = {1'b0, tx_q} + Ins;
        a_y   = {1'b0, ty_q} + (duck ? DuckDy : 11'd0) + Ins;
        a_w   = duck ? DuckW : StandW;
        a_h   = duck ? DuckH : StandH;
    end

    // Obstacle box; a dimension that the inset collapses to zero or less can never overlap.
    logic        b_w_ok, b_h_ok;
    logic [10:0] b_x, b_y, b_w, b_h;
    logic        hit_now;

    always_comb begin
        b_w_ok  = {4'b0, obs.obs_w} > Ins2;
        b_h_ok  = {4'b0, obs.obs_h} > Ins2;
        b_x     = {1'b0, obs.obs_x} + Ins;
        b_y     = {1'b0, obs.obs_y} + Ins;
        b_w     = {4'b0, obs.obs_w} - Ins2;
        b_h     = {4'b0, obs.obs_h} - Ins2;
        hit_now = obs.obs_valid && armed && b_w_ok && b_h_ok
                  && (a_x < b_x + b_w) && (b_x < a_x + a_w)
                  && (a_y < b_y + b_h) && (b_y < a_y + a_h);
    end

    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        ty_d    = ty_q;
        fr_d    = fr_q;
        idx_d   = idx_q;
        found_d = found_q;
        first_d = first_q;
        crash_d = crash_q;
        hit_d   = hit_q;

        unique case (state_q)
            StIdle: begin
                if (frame_tick) begin
                    tx_d    = trex_x;
                    ty_d    = trex_y;
                    fr_d    = trex_frame;
                    idx_d   = '0;
                    found_d = 1'b0;
                    first_d = '0;
                    state_d = StReq;
                end
            end
            StReq: begin
                state_d = StCmp;
            end
            StCmp: begin
                // Slots are visited in ascending order, so the first hit is the lowest.
                if (hit_now && !found_q) begin
                    found_d = 1'b1;
                    first_d = idx_q;
                end
                if (idx_q == LastIdx) begin
                    state_d = StFin;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = StReq;
                end
            end
            StFin: begin
                if (found_q && !crash_q) begin
                    crash_d = 1'b1;
                    hit_d   = first_q;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            tx_q    <= '0;
            ty_q    <= '0;
            fr_q    <= '0;
            idx_q   <= '0;
            found_q <= 1'b0;
            first_q <= '0;
            crash_q <= 1'b0;
            hit_q   <= '0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            ty_q    <= ty_d;
            fr_q    <= fr_d;
            idx_q   <= idx_d;
            found_q <= found_d;
            first_q <= first_d;
            crash_q <= crash_d;
            hit_q   <= hit_d;
        end
    end

    always_comb begin
        busy        = (state_q == StReq) || (state_q == StCmp);
        done        = (state_q == StFin);
        crash       = crash_q;
        hit_idx     = hit_q;
        obs.obs_idx = idx_q;
    end

endmodule

// File: tb/tb_trex_collision.sv
// Directed bench for trex_collision: behavioural obstacle table, scoreboard of expected
// scan results, immediate-assertion checks.
module tb_trex_collision;

    localparam int NUM   = 3;
    localparam int INSET = 2;
    localparam int IDXW  = 2;

    logic            clk;
    logic            rst;
    logic            frame_tick;
    logic [9:0]      trex_x;
    logic [9:0]      trex_y;
    logic [2:0]      trex_frame;
    logic            busy;
    logic            done;
    logic            crash;
    logic [IDXW-1:0] hit_idx;

    trex_collision_if #(.IDX_W(IDXW)) obs_bus ();

    trex_collision #(
        .NUM_OBSTACLES(NUM),
        .INSET(INSET),
        .IDX_W(IDXW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .frame_tick(frame_tick),
        .trex_x(trex_x),
        .trex_y(trex_y),
        .trex_frame(trex_frame),
        .obs(obs_bus),
        .busy(busy),
        .done(done),
        .crash(crash),
        .hit_idx(hit_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Obstacle table with a one-cycle registered read.
    bit tbl_v [4] = '{0, 0, 0, 0};
    int tbl_x [4] = '{0, 0, 0, 0};
    int tbl_y [4] = '{0, 0, 0, 0};
    int tbl_w [4] = '{0, 0, 0, 0};
    int tbl_h [4] = '{0, 0, 0, 0};

    always @(posedge clk) begin
        obs_bus.obs_valid <= tbl_v[obs_bus.obs_idx];
        obs_bus.obs_x     <= 10'(tbl_x[obs_bus.obs_idx]);
        obs_bus.obs_y     <= 10'(tbl_y[obs_bus.obs_idx]);
        obs_bus.obs_w     <= 7'(tbl_w[obs_bus.obs_idx]);
        obs_bus.obs_h     <= 7'(tbl_h[obs_bus.obs_idx]);
    end

    typedef struct {
        bit crash;
        int hit;
        int lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   crash_m = 0;
    int   hit_m = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_slot(input int s, input bit v, input int x, input int y,
                            input int w, input int h);
        tbl_v[s] = v;
        tbl_x[s] = x;
        tbl_y[s] = y;
        tbl_w[s] = w;
        tbl_h[s] = h;
    endtask

    function automatic bit model_hit(input int tx, input int ty, input int fr, input int s);
        int ax, ay, aw, ah, bx, by, bw, bh;
        if (!tbl_v[s] || fr < 2 || fr == 7) return 1'b0;
        ax = tx + INSET;
        if (fr == 5 || fr == 6) begin
            ay = ty + 22 + INSET;
            aw = 59 - 2 * INSET;
            ah = 25 - 2 * INSET;
        end else begin
            ay = ty + INSET;
            aw = 44 - 2 * INSET;
            ah = 47 - 2 * INSET;
        end
        bx = tbl_x[s] + INSET;
        by = tbl_y[s] + INSET;
        bw = tbl_w[s] - 2 * INSET;
        bh = tbl_h[s] - 2 * INSET;
        if (bw <= 0 || bh <= 0) return 1'b0;
        return (ax < bx + bw) && (bx < ax + aw) && (ay < by + bh) && (by < ay + ah);
    endfunction

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        frame_tick = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_crash"}, crash, 0);
        check({tag, "_hit_idx"}, hit_idx, 0);
        check({tag, "_obs_idx"}, obs_bus.obs_idx, 0);
        crash_m = 1'b0;
        hit_m = 0;
    endtask

    // extra_k/rst_k: cycle after the tick edge at which a second tick / a reset is sampled.
    task automatic do_scan(input string tag, input int tx, input int ty, input int fr,
                           input int extra_k, input int rst_k);
        bit   found;
        int   first;
        int   ndone;
        int   kdone;
        exp_t e;
        exp_t got;
        found = 1'b0;
        first = 0;
        for (int s = NUM - 1; s >= 0; s--) begin
            if (model_hit(tx, ty, fr, s)) begin
                found = 1'b1;
                first = s;
            end
        end
        e.crash = crash_m | found;
        e.hit   = (found && !crash_m) ? first : hit_m;
        e.lat   = 2 * NUM + 1;
        sb.push_back(e);
        got = e;

        @(negedge clk);
        trex_x = 10'(tx);
        trex_y = 10'(ty);
        trex_frame = 3'(fr);
        frame_tick = 1'b1;
        @(posedge clk);
        ndone = 0;
        kdone = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) check({tag, "_busy_start"}, busy, 1);
            if (done) begin
                ndone++;
                if (kdone == 0) begin
                    kdone = k;
                    check({tag, "_busy_in_fin"}, busy, 0);
                    got = sb.pop_front();
                    check({tag, "_latency"}, kdone, got.lat);
                end
            end
            if (k == 1) frame_tick = 1'b0;
            if (extra_k != 0 && k == extra_k) frame_tick = 1'b1;
            if (extra_k != 0 && k == extra_k + 1) frame_tick = 1'b0;
            if (rst_k != 0 && k == rst_k) rst = 1'b1;
            if (rst_k != 0 && k == rst_k + 1) rst = 1'b0;
        end
        if (sb.size() > 0) got = sb.pop_front();

        if (rst_k != 0) begin
            check({tag, "_abort_done_count"}, ndone, 0);
            check({tag, "_abort_busy"}, busy, 0);
            check({tag, "_abort_crash"}, crash, 0);
            check({tag, "_abort_hit_idx"}, hit_idx, 0);
            crash_m = 1'b0;
            hit_m = 0;
        end else begin
            check({tag, "_done_count"}, ndone, 1);
            check({tag, "_busy_end"}, busy, 0);
            check({tag, "_crash"}, crash, got.crash);
            check({tag, "_hit_idx"}, hit_idx, got.hit);
            crash_m = got.crash;
            hit_m = got.hit;
        end
    endtask

    initial begin
        rst = 1'b1;
        frame_tick = 1'b0;
        trex_x = '0;
        trex_y = '0;
        trex_frame = '0;
        do_reset("reset");

        // Standing hit on slot 0.
        set_slot(0, 1, 80, 110, 17, 35);
        do_scan("stand_hit", 50, 93, 2, 0, 0);

        // Inset edges just touch, then overlap by one pixel.
        do_reset("rst_t2");
        set_slot(0, 0, 0, 0, 0, 0);
        set_slot(1, 1, 90, 110, 17, 35);
        do_scan("edge_touch", 50, 93, 2, 0, 0);
        set_slot(1, 1, 89, 110, 17, 35);
        do_scan("edge_overlap", 50, 93, 2, 0, 0);

        // Ducking clears a bird that hits the standing box.
        do_reset("rst_t3a");
        set_slot(0, 1, 60, 90, 46, 20);
        set_slot(1, 0, 0, 0, 0, 0);
        do_scan("duck_clear", 50, 93, 5, 0, 0);
        do_reset("rst_t3b");
        do_scan("stand_bird", 50, 93, 2, 0, 0);

        // Two overlapping slots; idle and crashed frames never hit.
        do_reset("rst_t4");
        set_slot(0, 0, 0, 0, 0, 0);
        set_slot(1, 1, 80, 110, 17, 35);
        set_slot(2, 1, 70, 100, 10, 40);
        do_scan("waiting_frame", 50, 93, 0, 0, 0);
        do_scan("crashed_frame", 50, 93, 7, 0, 0);
        do_scan("multi_hit", 50, 93, 3, 0, 0);

        // Tick while busy is dropped; reset mid-scan aborts.
        do_reset("rst_t5a");
        do_scan("busy_tick", 50, 93, 2, 3, 0);
        do_reset("rst_t5b");
        do_scan("mid_rst", 50, 93, 2, 0, 4);

        // Crash is sticky and hit_idx is frozen once set.
        do_reset("rst_t6");
        do_scan("sticky_set", 50, 93, 4, 0, 0);
        set_slot(1, 0, 0, 0, 0, 0);
        set_slot(2, 0, 0, 0, 0, 0);
        do_scan("sticky_empty", 50, 93, 2, 0, 0);
        set_slot(0, 1, 80, 110, 17, 35);
        do_scan("sticky_newhit", 50, 93, 2, 0, 0);
        do_reset("final_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/trex_collision.md
Name: trex_collision

Overview:
- Downstream neighbour of the T-rex character block.
- On every game frame tick it takes the character's x_pos/y_pos/frame and scans the obstacle table, testing inset bounding-box overlap.
- It raises a sticky crash level that feeds back into the character's crash input.
- Obstacle data is read through a registered-read port with 1-cycle latency, driven by the obstacle manager.

Parameters:
NUM_OBSTACLES, 3, number of obstacle slots scanned per check (1..4)
INSET, 2, pixels trimmed from every edge of both boxes before comparison
IDX_W, 2, width of obs_idx and hit_idx

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
frame_tick  input  1  one-cycle pulse; starts a check
trex_x  input  10  character left edge
trex_y  input  10  character top edge (standing sprite)
trex_frame  input  3  frame code: 0,1 WAITING; 2,3 RUNNING; 4 JUMPING; 5,6 DUCKING; 7 CRASHED
obs_idx  output  IDX_W  obstacle slot being requested
obs_valid  input  1  slot occupied; valid the cycle after obs_idx is driven
obs_x  input  10  obstacle left edge
obs_y  input  10  obstacle top edge
obs_w  input  7  obstacle width
obs_h  input  7  obstacle height
busy  output  1  scan in progress
done  output  1  one-cycle pulse when a scan completes
crash  output  1  sticky collision flag
hit_idx  output  IDX_W  lowest colliding slot of the scan that set crash

Behaviour:
- Reset values: busy=0, done=0, crash=0, hit_idx=0, obs_idx=0. FSM goes to IDLE.
- FSM states: IDLE, REQ, CMP, FIN.
- IDLE: frame_tick=1 captures trex_x, trex_y and trex_frame into registers and moves to REQ with index i=0. The next-cycle busy is 1.
- REQ: drives obs_idx=i, then moves to CMP.
- CMP:
  - Samples obs_* and evaluates the overlap for slot i.
  - If i<NUM_OBSTACLES-1, increments i and returns to REQ; otherwise moves to FIN.
- FIN: done=1 for one cycle, busy=0, then returns to IDLE.
- Latency: tick sampled at cycle T gives done at T+2*NUM_OBSTACLES+1 (T+7 at the default).
- crash/hit_idx are updated in the FIN cycle.
- frame_tick while busy is ignored, with no queueing. A tick in the FIN cycle is also ignored.
- Trex box from the captured frame:
  - Frames 5,6: x=trex_x, y=trex_y+22, w=59, h=25.
  - All others: x=trex_x, y=trex_y, w=44, h=47.
- Inset applies to both boxes: x+=INSET, y+=INSET, w-=2*INSET, h-=2*INSET.
- Overlap is strict: ax<bx+bw AND bx<ax+aw AND ay<by+bh AND by<ay+ah. Edges that only touch do not collide.
- All sums use 11-bit unsigned arithmetic, so there is no wrap.
- A slot with obs_valid=0 never hits.
- Frames 0,1 (WAITING) and 7 (CRASHED) run the full scan with identical latency but never set crash.
- Scan result:
  - At least one hit sets crash=1 and hit_idx to the lowest hit index.
  - A scan with no hit leaves crash and hit_idx unchanged.
- crash stays 1 until rst. Scans while crash=1 still run but do not modify hit_idx.
- rst mid-scan aborts to IDLE with reset values and no done pulse.

Test Plan:
1. Standing hit. Tick with trex (50,93) frame 2 and slot0 valid (80,110,17,35); slots 1,2 invalid. Required: done at T+7, crash=1, hit_idx=0.
2. Edge boundary. Same trex with slot1 valid (90,110,17,35): insets meet at x=92, so no crash. Then slot1 x=89: crash=1, hit_idx=1.
3. Duck under a bird. Slot0 (60,90,46,20).
   - Trex (50,93) frame 5: no crash.
   - After rst, same obstacle with frame 2: crash=1.
4. Multiple hits and non-hitting frames.
   - Slots 1 and 2 both overlap: hit_idx=1.
   - Same stimulus with frame 0 or 7: done pulses at T+7 and crash stays 0.
5. Tick handling. A second frame_tick at T+3 is ignored, with exactly one done pulse. rst at T+4 gives busy=0, no done, crash=0.
6. Sticky crash. After crash=1, a scan with no obstacles keeps crash=1 and hit_idx unchanged. Following rst, all outputs are 0.
